// File: rtl/p_acc.sv
// p_acc: batch accumulator for p_sub operands; one O_CONF sum per LEN accepts with sticky flags.
// Define P_ACC_SAT_EN to clamp the stored sum on overflow/underflow; otherwise it wraps.
package p_acc_pkg;
  typedef enum logic {INT, FXP} dtype_e;
  typedef struct packed {
    dtype_e dtype;
    logic   sign;
    int     prec;
    int     frac;
  } dconf_t;
endpackage

module p_acc
  import p_acc_pkg::*;
#(
  parameter dconf_t I_CONF = '{INT, 1'b1, 8, 0},
  parameter dconf_t O_CONF = '{INT, 1'b1, 16, 0},
  parameter int     LEN    = 4,
  localparam int    I_PREC = I_CONF.prec,
  localparam int    O_PREC = O_CONF.prec
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [I_PREC-1:0] in,
  input  logic              in_ovf,
  input  logic              in_udf,
  input  logic              in_rounded,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [O_PREC-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  output logic              udf,
  output logic              rounded
);
  localparam int   W      = O_PREC + 2;
  localparam int   SH     = O_CONF.frac - I_CONF.frac;
  localparam int   CW     = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic I_SIGN = I_CONF.sign;
  localparam logic O_SIGN = O_CONF.sign;

  localparam logic signed [W-1:0] ONE  = W'(1);
  localparam logic signed [W-1:0] MAXV = O_SIGN ? (ONE <<< (O_PREC-1)) - ONE
                                                : (ONE <<< O_PREC) - ONE;
  localparam logic signed [W-1:0] MINV = O_SIGN ? -(ONE <<< (O_PREC-1)) : '0;

  typedef enum logic {ACC, HOLD} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [O_PREC-1:0]  acc_q, acc_d;
  logic               ovf_q, udf_q, rnd_q, out_valid_q;
  logic signed [W-1:0] in_ext, aligned, acc_ext, sum;
  logic               ovf_det, udf_det, accept;

  assign in_ext  = {{(W-I_PREC){I_SIGN & in[I_PREC-1]}}, in};
  assign aligned = in_ext <<< SH;
  assign acc_ext = {{2{O_SIGN & acc_q[O_PREC-1]}}, acc_q};
  assign sum     = acc_ext + aligned;
  assign ovf_det = sum > MAXV;
  assign udf_det = sum < MINV;

  always_comb begin
    acc_d = sum[O_PREC-1:0];
`ifdef P_ACC_SAT_EN
    if (ovf_det)      acc_d = MAXV[O_PREC-1:0];
    else if (udf_det) acc_d = MINV[O_PREC-1:0];
`endif
  end

  // Ready depends only on state (and reset), never on in_valid.
  assign in_ready = (state_q == ACC) & ~reset;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      rnd_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: if (accept) begin
          acc_q <= acc_d;
          ovf_q <= ovf_q | in_ovf | ovf_det;
          udf_q <= udf_q | in_udf | udf_det;
          rnd_q <= rnd_q | in_rounded;
          if (cnt_q == CW'(LEN-1)) begin
            cnt_q       <= '0;
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HOLD: if (out_ready) begin
          // Handoff edge clears the batch so the next element starts from zero.
          state_q     <= ACC;
          out_valid_q <= 1'b0;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
          udf_q       <= 1'b0;
          rnd_q       <= 1'b0;
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign out       = acc_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign rounded   = rnd_q;
endmodule

// File: tb/tb_p_acc.sv
// Randomized bench for p_acc: INT 8->8 LEN=4 instance plus an FXP alignment instance, vs integer model.
module tb_p_acc;
  import p_acc_pkg::*;

  logic clk = 0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  din;
  logic        d_ovf, d_udf, d_rnd, din_valid, din_ready;
  logic [7:0]  dout;
  logic        dout_valid, dout_ready, o_ovf, o_udf, o_rnd;

  logic [7:0]  fin;
  logic        f_zero, fin_valid, fin_ready;
  logic [15:0] fout;
  logic        fout_valid, fout_ready, fo_ovf, fo_udf, fo_rnd;

  int n_chk = 0;
  int n_err = 0;

  p_acc #(.I_CONF('{INT, 1'b1, 8, 0}), .O_CONF('{INT, 1'b1, 8, 0}), .LEN(4)) u_dut (
    .clk(clk), .reset(reset), .in(din), .in_ovf(d_ovf), .in_udf(d_udf), .in_rounded(d_rnd),
    .in_valid(din_valid), .in_ready(din_ready), .out(dout), .out_valid(dout_valid),
    .out_ready(dout_ready), .ovf(o_ovf), .udf(o_udf), .rounded(o_rnd));

  p_acc #(.I_CONF('{FXP, 1'b1, 8, 2}), .O_CONF('{FXP, 1'b1, 16, 4}), .LEN(4)) u_fxp (
    .clk(clk), .reset(reset), .in(fin), .in_ovf(f_zero), .in_udf(f_zero), .in_rounded(f_zero),
    .in_valid(fin_valid), .in_ready(fin_ready), .out(fout), .out_valid(fout_valid),
    .out_ready(fout_ready), .ovf(fo_ovf), .udf(fo_udf), .rounded(fo_rnd));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer running sum with range check, clamp or modular wrap.
  function automatic void model(input int v[4], input int sh, input int prec,
                                output longint res, output bit o, output bit u);
    longint mx, mn, m, a, s;
    m  = longint'(1) <<< prec;
    mx = (m / 2) - 1;
    mn = -(m / 2);
    a = 0; o = 0; u = 0;
    for (int i = 0; i < 4; i++) begin
      s = a + longint'(v[i]) * (longint'(1) <<< sh);
      if (s > mx) o = 1;
      if (s < mn) u = 1;
`ifdef P_ACC_SAT_EN
      a = (s > mx) ? mx : (s < mn) ? mn : s;
`else
      a = (((s - mn) % m) + m) % m + mn;
`endif
    end
    res = a;
  endfunction

  task automatic push(input int v, input int fl, input int gap);
    int t;
    din_valid = 0;
    repeat ($urandom_range(gap, 0)) @(negedge clk);
    @(negedge clk);
    din = 8'(v); d_ovf = fl[0]; d_udf = fl[1]; d_rnd = fl[2]; din_valid = 1;
    t = 0;
    while (!din_ready && t < 20) begin @(negedge clk); t++; end
    if (!din_ready) chk("push.timeout", din_ready, 1);
    @(posedge clk); #1;
    din_valid = 0; d_ovf = 0; d_udf = 0; d_rnd = 0;
  endtask

  task automatic run_batch(input string tag, input int v[4], input int fl[4],
                           input int gap, input int hold);
    longint er; bit eo, eu, erd;
    logic [7:0] saved;
    model(v, 0, 8, er, eo, eu);
    erd = 0;
    for (int i = 0; i < 4; i++) begin
      eo |= fl[i][0]; eu |= fl[i][1]; erd |= fl[i][2];
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) chk({tag, ".early_valid"}, dout_valid, 0);
      push(v[i], fl[i], gap);
    end
    chk({tag, ".lat"}, dout_valid, 1);
    chk({tag, ".out"}, longint'($signed(dout)), er);
    chk({tag, ".ovf"}, o_ovf, eo);
    chk({tag, ".udf"}, o_udf, eu);
    chk({tag, ".rnd"}, o_rnd, erd);
    saved = dout;
    // Offer a junk operand throughout HOLD and handoff; it must not be taken.
    din = 8'($urandom_range(255)); din_valid = 1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, ".bp_out"}, dout, saved);
      chk({tag, ".bp_rdy"}, din_ready, 0);
      chk({tag, ".bp_vld"}, dout_valid, 1);
    end
    @(negedge clk); dout_ready = 1;
    chk({tag, ".hand_rdy"}, din_ready, 0);
    @(posedge clk); #1;
    dout_ready = 0; din_valid = 0;
    chk({tag, ".rel_vld"}, dout_valid, 0);
    chk({tag, ".rel_rdy"}, din_ready, 1);
  endtask

  task automatic push_f(input int v);
    int t;
    @(negedge clk);
    fin = 8'(v); fin_valid = 1;
    t = 0;
    while (!fin_ready && t < 20) begin @(negedge clk); t++; end
    if (!fin_ready) chk("fxp.push.timeout", fin_ready, 1);
    @(posedge clk); #1;
    fin_valid = 0;
  endtask

  task automatic fxp_batch(input string tag, input int v[4]);
    longint er; bit eo, eu;
    model(v, 2, 16, er, eo, eu);
    for (int i = 0; i < 4; i++) push_f(v[i]);
    chk({tag, ".lat"}, fout_valid, 1);
    chk({tag, ".out"}, longint'($signed(fout)), er);
    chk({tag, ".ovf"}, fo_ovf, eo);
    chk({tag, ".udf"}, fo_udf, eu);
    @(negedge clk); fout_ready = 1;
    @(posedge clk); #1; fout_ready = 0;
    chk({tag, ".rel"}, fout_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[4], fl[4];
    reset = 1; din = 0; d_ovf = 0; d_udf = 0; d_rnd = 0; din_valid = 0; dout_ready = 0;
    fin = 0; f_zero = 0; fin_valid = 0; fout_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", din_ready, 0);
    chk("rst.out_valid", dout_valid, 0);
    chk("rst.out", dout, 0);
    chk("rst.flags", {o_ovf, o_udf, o_rnd}, 0);
    reset = 0; #1;
    chk("rst.ready_after", din_ready, 1);

    run_batch("basic", '{3, -1, 5, 2}, '{0, 0, 0, 0}, 0, 0);
    run_batch("ovf",   '{100, 100, -50, 10}, '{0, 0, 0, 0}, 0, 0);
    run_batch("udf",   '{-100, -100, 0, 0}, '{0, 0, 0, 0}, 0, 0);
    run_batch("bp",    '{20, -3, 7, 1}, '{0, 0, 0, 0}, 0, 5);
    run_batch("post_bp", '{1, 1, 1, 1}, '{0, 0, 0, 0}, 0, 0);
    run_batch("rnd",   '{4, 5, 6, 7}, '{0, 4, 0, 0}, 0, 0);
    run_batch("clean", '{4, 5, 6, 7}, '{0, 0, 0, 0}, 0, 0);

    // Mid-batch reset discards the partial sum.
    push(7, 0, 0);
    push(7, 0, 0);
    @(negedge clk); reset = 1; #1;
    chk("mrst.in_ready", din_ready, 0);
    @(negedge clk); reset = 0; #1;
    chk("mrst.out", dout, 0);
    chk("mrst.out_valid", dout_valid, 0);
    run_batch("mrst", '{1, 2, 3, 4}, '{0, 0, 0, 0}, 0, 0);

    for (int b = 0; b < 15; b++) begin
      for (int i = 0; i < 4; i++) begin
        v[i]  = int'($urandom_range(255)) - 128;
        fl[i] = ($urandom_range(7) == 0) ? int'($urandom_range(7)) : 0;
      end
      run_batch("rand", v, fl, 2, int'($urandom_range(3)));
    end

    fxp_batch("fxp", '{6, 6, 6, 6});
    for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(255)) - 128;
    fxp_batch("fxp_rand", v);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
